// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART byte FIFO.
package uart_fifo_pkg;

  localparam int UART_FIFO_DATA_W = 8;
  localparam int UART_FIFO_DEPTH  = 64;
  localparam int UART_FIFO_LOAD_W = 7;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous (combinational) read
// port so the head entry falls through to the consumer with no read latency.
// Contents are intentionally not reset.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_FIFO_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the incoming entry into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO between the UART datapath and its consumer.
// Optional build macro: UART_FIFO_FULL_PUSHPOP_EN -- when defined, a write is
// accepted while full provided the head is popped in the same cycle (this adds
// a combinational m_ready -> s_ready path). Undefined by default.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_FIFO_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int LOAD_W = UART_FIFO_LOAD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [LOAD_W-1:0] s_load,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LOAD_W-1:0] m_load
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [LOAD_W-1:0] DEPTH_L = LOAD_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LOAD_W-1:0] count_reg;
  // Holds s_ready low during reset and until the first clock afterwards.
  logic              ready_en_reg;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  assign full  = (count_reg == DEPTH_L);
  assign empty = (count_reg == '0);

`ifdef UART_FIFO_FULL_PUSHPOP_EN
  // While full, a simultaneous pop frees the slot the write lands in.
  assign s_ready = ready_en_reg && (!full || m_ready);
`else
  assign s_ready = ready_en_reg && !full;
`endif

  assign m_valid = !empty;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Pointer, occupancy and ready-enable state with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LOAD_W'(1);
        2'b01:   count_reg <= count_reg - LOAD_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (s_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Force zero on an empty FIFO so the unreset storage never leaks out.
  assign m_data = empty ? '0 : rd_data;
  assign m_load = count_reg;
  assign s_load = DEPTH_L - count_reg;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: a negedge monitor keeps a reference
// occupancy and a queue of accepted bytes, and compares every pop.
module tb_uart_fifo;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [6:0] s_load;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [6:0] m_load;

  int         checks;
  int         errors;
  int         mcount;
  int         pops_seen;
  bit         mon_en;
  logic [7:0] exp_q[$];

  uart_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_load  (s_load),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_load  (m_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model evaluated mid-cycle, predicting the coming rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit full_m, rdy_m, push_m, pop_m;
      full_m = (mcount == 64);
`ifdef UART_FIFO_FULL_PUSHPOP_EN
      rdy_m = !full_m || m_ready;
`else
      rdy_m = !full_m;
`endif
      check_value("s_ready", s_ready, rdy_m);
      check_value("m_valid", m_valid, mcount != 0);
      check_value("m_load", m_load, mcount);
      check_value("s_load", s_load, 64 - mcount);
      pop_m  = m_ready && (mcount != 0);
      push_m = s_valid && rdy_m;
      if (pop_m) begin
        if (exp_q.size() == 0) begin
          check_value("pop_underflow", 1, 0);
        end else begin
          check_value("m_data", m_data, exp_q.pop_front());
        end
        pops_seen++;
      end
      if (push_m) exp_q.push_back(s_data);
      mcount = mcount + int'(push_m) - int'(pop_m);
    end
  end

  initial begin
    int base;
    checks = 0; errors = 0; mcount = 0; pops_seen = 0; mon_en = 0;
    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;

    // Reset values while held
    repeat (3) step();
    check_value("rst_s_ready", s_ready, 0);
    check_value("rst_s_load", s_load, 64);
    check_value("rst_m_valid", m_valid, 0);
    check_value("rst_m_load", m_load, 0);
    check_value("rst_m_data", m_data, 0);
    rst = 1'b1;
    step();
    check_value("post_rst_s_ready", s_ready, 1);
    check_value("post_rst_s_load", s_load, 64);
    check_value("post_rst_m_valid", m_valid, 0);
    check_value("post_rst_m_load", m_load, 0);
    mon_en = 1;

    // Single write then single read
    s_valid = 1'b1; s_data = 8'hFF;
    step();
    s_valid = 1'b0;
    check_value("single_m_valid", m_valid, 1);
    check_value("single_m_data", m_data, 8'hFF);
    check_value("single_m_load", m_load, 1);
    check_value("single_s_load", s_load, 63);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check_value("single_pop_m_valid", m_valid, 0);
    check_value("single_pop_m_load", m_load, 0);

    // Fill to full, drop a 65th byte, drain in order
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      step();
    end
    check_value("full_s_ready", s_ready, 0);
    check_value("full_s_load", s_load, 0);
    check_value("full_m_load", m_load, 64);
    s_data = 8'hAA;
    step();
    s_valid = 1'b0;
    check_value("drop_m_load", m_load, 64);
    base = pops_seen;
    m_ready = 1'b1;
    repeat (64) step();
    m_ready = 1'b0;
    check_value("drain_pops", pops_seen - base, 64);
    check_value("drain_m_load", m_load, 0);
    check_value("drain_m_valid", m_valid, 0);

    // Streaming: steady occupancy of one
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = 8'(8'h40 + i);
      step();
      check_value("stream_m_load", m_load, 1);
    end
    s_valid = 1'b0;
    step();
    m_ready = 1'b0;
    check_value("stream_end_m_load", m_load, 0);

    // Wrap-around: two rounds of 40 in / 40 out
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 40; i++) begin
        s_valid = 1'b1; s_data = 8'(8'hC0 ^ (r * 40 + i));
        step();
      end
      s_valid = 1'b0;
      check_value("wrap_fill_m_load", m_load, 40);
      m_ready = 1'b1;
      repeat (40) step();
      m_ready = 1'b0;
    end
    check_value("wrap_s_load", s_load, 64);
    check_value("wrap_m_load", m_load, 0);

    // Full plus simultaneous pop
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h80 + i);
      step();
    end
    s_data = 8'h5A; m_ready = 1'b1;
    step();
    s_valid = 1'b0; m_ready = 1'b0;
`ifdef UART_FIFO_FULL_PUSHPOP_EN
    check_value("fullpop_m_load", m_load, 64);
`else
    check_value("fullpop_m_load", m_load, 63);
    check_value("fullpop_s_ready", s_ready, 1);
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 70 && m_valid; i++) step();
    m_ready = 1'b0;
    check_value("fullpop_drained", m_valid, 0);
    check_value("fullpop_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of traffic
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(8'h10 + i);
      step();
    end
    #3;
    mon_en = 0;
    rst = 1'b0;
    #1;
    check_value("async_s_ready", s_ready, 0);
    check_value("async_s_load", s_load, 64);
    check_value("async_m_valid", m_valid, 0);
    check_value("async_m_load", m_load, 0);
    check_value("async_m_data", m_data, 0);
    s_valid = 1'b0;
    exp_q.delete();
    mcount = 0;
    step();
    rst = 1'b1;
    step();
    check_value("rerst_s_ready", s_ready, 1);
    mon_en = 1;
    s_valid = 1'b1; s_data = 8'h33;
    step();
    s_valid = 1'b0;
    check_value("rerst_m_data", m_data, 8'h33);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check_value("rerst_m_valid", m_valid, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Single-clock, first-word-fall-through byte FIFO.
- Buffers bytes between the UART datapath and its consumer.
- Valid/ready handshake on both the write side (s_*) and the read side (m_*).
- Reports occupancy as "load" counts on both sides.

Parameters:
- DATA_W, 8, data width in bits.
- DEPTH, 64, number of entries; must be a power of two.
- LOAD_W, 7, load counter width; equals clog2(DEPTH)+1 so the value DEPTH is representable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  write request.
- s_ready  out  1  FIFO can accept a write.
- s_data  in  DATA_W  write data.
- s_load  out  LOAD_W  free entries (DEPTH minus occupancy).
- m_valid  out  1  head entry available.
- m_ready  in  1  consumer takes the head entry.
- m_data  out  DATA_W  head entry data (first-word-fall-through).
- m_load  out  LOAD_W  occupied entries.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-low.
  - While rst=0: write/read pointers=0, count=0, s_ready=0, s_load=DEPTH (64), m_valid=0, m_load=0, m_data=0.
  - After rst deasserts: s_ready=1 from the first clock.
- Handshakes:
  - push = s_valid && s_ready.
  - pop = m_valid && m_ready.
  - Both are evaluated at the rising edge.
  - s_valid while s_ready=0 is ignored; data is not latched and there is no error flag.
  - m_ready while m_valid=0 is ignored.
- Flags:
  - s_ready = (count != DEPTH).
  - m_valid = (count != 0).
  - Both derive from registered state only, with no combinational path from inputs.
- Count and load outputs:
  - count' = count + push - pop; unchanged when push and pop occur together.
  - m_load = count.
  - s_load = DEPTH - count.
  - Invariant: s_load + m_load = DEPTH at all times.
- Data path:
  - m_data = mem[rd_ptr], a combinational read of the head.
  - Its value is don't-care when m_valid=0, except after reset, where it is 0.
- Latency:
  - A byte pushed at edge N is visible with m_valid=1 after edge N (one cycle).
  - No empty-FIFO bypass.
- Pointers:
  - log2(DEPTH) bits; wrap from DEPTH-1 to 0 naturally.
  - The write pointer advances on push, the read pointer on pop.
- Boundary conditions:
  - Full: s_ready=0, so push=0 even if pop=1 that cycle. s_ready returns the cycle after a pop.
  - Empty: pop=0; a push still occurs.
  - Push and pop together, not full and not empty: both pointers advance and count is unchanged.
  - Reset mid-operation: all contents are discarded and outputs return to reset values immediately (asynchronous).
- Memory contents are not reset; only the pointers and count are.

Optional Feature:
- UART_FIFO_FULL_PUSHPOP_EN defined:
  - s_ready = (count != DEPTH) || m_ready.
  - A push while full and popping is accepted; count stays DEPTH.
  - The write goes to the slot being freed (wr_ptr == rd_ptr); the head read uses the pre-edge data.
  - Adds a combinational m_ready->s_ready path.
- Undefined: s_ready is purely registered-state derived, as specified above.

Decomposition:
- Package uart_fifo_pkg:
  - localparams UART_FIFO_DATA_W=8, UART_FIFO_DEPTH=64, UART_FIFO_LOAD_W=7.
  - typedef uart_byte_t (logic [7:0]).
- Sub-module uart_fifo_mem:
  - Storage array with a synchronous write port and an asynchronous read port.
  - Parameterized by DATA_W and DEPTH.
- The top block holds pointers, count, flags and loads.

Test Plan:
- Reset: hold rst=0, then release -> s_ready=1, s_load=64, m_valid=0, m_load=0. Assert rst mid-traffic -> same values immediately, without waiting for a clock.
- Single write: s_data=8'hFF with s_valid pulsed for one cycle, m_ready=0 -> next cycle m_valid=1, m_data=8'hFF, m_load=1, s_load=63. Then m_ready=1 for one cycle -> m_valid=0, m_load=0.
- Fill: push 64 bytes 0x00..0x3F with m_ready=0 -> s_ready=0, s_load=0, m_load=64. A 65th push of 0xAA is dropped. Drain -> 0x00..0x3F in order, no 0xAA.
- Streaming: s_valid=1 and m_ready=1 continuously with incrementing data -> after one cycle of latency, m_load stays at 1 and the output sequence equals the input sequence.
- Wrap-around: push 40, pop 40, push 40, pop 40 -> data integrity across the pointer wrap; loads return to 64/0.
- Full plus pop: at count=64 with s_valid=1 and m_ready=1 -> without the macro, count becomes 63 and the byte is not accepted; with UART_FIFO_FULL_PUSHPOP_EN, count stays 64 and the byte appears at the tail.
